// File: rtl/stack_sequencer.sv
// ---------------------------------------------------------------------------
// stack_sequencer
//
// Sits between the decode control unit and the ID/EX register. It expands
// CALL, RET, RTI and external interrupts into short sequences of stack
// micro-op control words (PUSH_PC, PUSH_FLAGS, POP_PC, POP_FLAGS). Every
// other instruction passes through with one cycle of latency. While a
// sequence runs, or while an interrupt is waiting to be taken, the fetch
// and decode stages are held.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   ctrl_in      decoded control word from the control unit
//   valid_in     ctrl_in holds a real instruction
//   int_req      external interrupt request (level)
//   stall_in     downstream hazard/memory stall, freezes the block
//   ctrl_out     registered control word to ID/EX
//   valid_out    ctrl_out is a real slot
//   stall_fetch  upstream must hold PC, IF/ID and ctrl_in (combinational)
//   int_ack      one-cycle pulse when an interrupt is taken
//   int_vec_sel  PC source = interrupt vector, aligned with the final
//                branch word of the interrupt sequence
// ---------------------------------------------------------------------------

// Run-time consistency checks on the sequencer outputs.
module stack_sequencer_checker #(
    parameter int                CTRL_W        = 34,
    parameter logic [CTRL_W-1:0] WORD_BRANCH   = '0,
    parameter logic [CTRL_W-1:0] WORD_INT_PUSH = '0,
    parameter logic [CTRL_W-1:0] STACK_MASK    = '0
) (
    input logic              clk,
    input logic              rst_n,
    input logic [CTRL_W-1:0] ctrl_out,
    input logic              valid_out,
    input logic              stall_fetch,
    input logic              int_ack,
    input logic              int_vec_sel
);

    // Check that the vector select, the acknowledge and stack micro-op bits
    // only ever appear on the slots that are allowed to carry them.
    always @(posedge clk) begin
        if (rst_n) begin
            if (int_vec_sel) begin
                assert (valid_out && (ctrl_out == WORD_BRANCH));
            end
            if (int_ack) begin
                assert (valid_out && stall_fetch && (ctrl_out == WORD_INT_PUSH));
            end
            if ((ctrl_out & STACK_MASK) != '0) begin
                assert (valid_out);
            end
        end
    end

endmodule

module stack_sequencer #(
    parameter int CTRL_W = 34,
    parameter bit INT_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              valid_in,
    input  logic              int_req,
    input  logic              stall_in,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic              valid_out,
    output logic              stall_fetch,
    output logic              int_ack,
    output logic              int_vec_sel
);

    // Control word bit positions, shared with the decoder.
    localparam int B_BRANCH     = 0;
    localparam int B_MEMWRITE   = 1;
    localparam int B_MEMREAD    = 2;
    localparam int B_RTI        = 4;
    localparam int B_RET        = 5;
    localparam int B_CALL       = 6;
    localparam int B_PUSH_PC    = 30;
    localparam int B_PUSH_FLAGS = 31;
    localparam int B_POP_PC     = 32;
    localparam int B_POP_FLAGS  = 33;

    // One-hot control word with a single bit set.
    function automatic logic [CTRL_W-1:0] onehot(input int idx);
        logic [CTRL_W-1:0] w;
        w      = '0;
        w[idx] = 1'b1;
        return w;
    endfunction

    // Micro-op words emitted by the sequences.
    localparam logic [CTRL_W-1:0] W_PUSH_PC    = onehot(B_PUSH_PC)    | onehot(B_MEMWRITE);
    localparam logic [CTRL_W-1:0] W_PUSH_FLAGS = onehot(B_PUSH_FLAGS) | onehot(B_MEMWRITE);
    localparam logic [CTRL_W-1:0] W_POP_PC     = onehot(B_POP_PC)     | onehot(B_MEMREAD);
    localparam logic [CTRL_W-1:0] W_POP_FLAGS  = onehot(B_POP_FLAGS)  | onehot(B_MEMREAD);
    localparam logic [CTRL_W-1:0] W_BRANCH     = onehot(B_BRANCH);
    localparam logic [CTRL_W-1:0] W_RTI_FIN    = onehot(B_RTI)  | onehot(B_BRANCH);
    localparam logic [CTRL_W-1:0] W_RET_FIN    = onehot(B_RET)  | onehot(B_BRANCH);
    localparam logic [CTRL_W-1:0] W_CALL_FIN   = onehot(B_CALL) | onehot(B_BRANCH);

    // Stack micro-op bits are owned by this block; the decoder never drives
    // them, so they are scrubbed from pass-through words.
    localparam logic [CTRL_W-1:0] STACK_MASK = onehot(B_PUSH_PC) | onehot(B_PUSH_FLAGS) |
                                               onehot(B_POP_PC)  | onehot(B_POP_FLAGS);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INT_PF   = 3'd1,
        ST_INT_FIN  = 3'd2,
        ST_RTI_PC   = 3'd3,
        ST_RTI_FIN  = 3'd4,
        ST_RET_FIN  = 3'd5,
        ST_CALL_FIN = 3'd6
    } state_t;

    state_t            state_r;
    logic              int_pending_r;
    logic [CTRL_W-1:0] ctrl_out_r;
    logic              valid_out_r;
    logic              int_ack_r;
    logic              int_vec_sel_r;
    logic              int_req_s;

    assign int_req_s   = int_req && INT_EN;
    assign ctrl_out    = ctrl_out_r;
    assign valid_out   = valid_out_r;
    assign int_ack     = int_ack_r;
    assign int_vec_sel = int_vec_sel_r;

    // Fetch is held while a sequence runs and while an interrupt waits in
    // IDLE; that waiting cycle is part of the interrupt's fetch stall.
    always_comb begin
        if ((state_r != ST_IDLE) || int_pending_r) begin
            stall_fetch = 1'b1;
        end else begin
            stall_fetch = 1'b0;
        end
    end

    // Sequencer FSM, interrupt latch and registered output slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            int_pending_r <= 1'b0;
            ctrl_out_r    <= '0;
            valid_out_r   <= 1'b0;
            int_ack_r     <= 1'b0;
            int_vec_sel_r <= 1'b0;
        end else begin
            // The request latches even while frozen by stall_in; the clear
            // below (when the interrupt is taken) overrides it.
            if (int_req_s) begin
                int_pending_r <= 1'b1;
            end

            if (stall_in) begin
                // Frozen: slot, state and vector select hold; the ack pulse
                // must not be stretched.
                int_ack_r <= 1'b0;
            end else begin
                int_ack_r     <= 1'b0;
                int_vec_sel_r <= 1'b0;
                case (state_r)
                    ST_IDLE: begin
                        if (int_pending_r) begin
                            // Interrupt wins over ctrl_in, which stays unconsumed
                            // because stall_fetch is already high this cycle.
                            ctrl_out_r    <= W_PUSH_PC;
                            valid_out_r   <= 1'b1;
                            int_ack_r     <= 1'b1;
                            int_pending_r <= 1'b0;
                            state_r       <= ST_INT_PF;
                        end else if (!valid_in) begin
                            ctrl_out_r  <= '0;
                            valid_out_r <= 1'b0;
                        end else if (ctrl_in[B_RTI]) begin
                            ctrl_out_r  <= W_POP_FLAGS;
                            valid_out_r <= 1'b1;
                            state_r     <= ST_RTI_PC;
                        end else if (ctrl_in[B_RET]) begin
                            ctrl_out_r  <= W_POP_PC;
                            valid_out_r <= 1'b1;
                            state_r     <= ST_RET_FIN;
                        end else if (ctrl_in[B_CALL]) begin
                            ctrl_out_r  <= W_PUSH_PC;
                            valid_out_r <= 1'b1;
                            state_r     <= ST_CALL_FIN;
                        end else begin
                            ctrl_out_r  <= ctrl_in & ~STACK_MASK;
                            valid_out_r <= 1'b1;
                        end
                    end
                    ST_INT_PF: begin
                        ctrl_out_r  <= W_PUSH_FLAGS;
                        valid_out_r <= 1'b1;
                        state_r     <= ST_INT_FIN;
                    end
                    ST_INT_FIN: begin
                        ctrl_out_r    <= W_BRANCH;
                        valid_out_r   <= 1'b1;
                        int_vec_sel_r <= 1'b1;
                        state_r       <= ST_IDLE;
                    end
                    ST_RTI_PC: begin
                        ctrl_out_r  <= W_POP_PC;
                        valid_out_r <= 1'b1;
                        state_r     <= ST_RTI_FIN;
                    end
                    ST_RTI_FIN: begin
                        ctrl_out_r  <= W_RTI_FIN;
                        valid_out_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                    ST_RET_FIN: begin
                        ctrl_out_r  <= W_RET_FIN;
                        valid_out_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                    ST_CALL_FIN: begin
                        ctrl_out_r  <= W_CALL_FIN;
                        valid_out_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                    default: begin
                        // Unreachable encoding: recover to a bubble in IDLE.
                        ctrl_out_r  <= '0;
                        valid_out_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    stack_sequencer_checker #(
        .CTRL_W       (CTRL_W),
        .WORD_BRANCH  (W_BRANCH),
        .WORD_INT_PUSH(W_PUSH_PC),
        .STACK_MASK   (STACK_MASK)
    ) u_checker (
        .clk        (clk),
        .rst_n      (rst_n),
        .ctrl_out   (ctrl_out),
        .valid_out  (valid_out),
        .stall_fetch(stall_fetch),
        .int_ack    (int_ack),
        .int_vec_sel(int_vec_sel)
    );

endmodule

// File: tb/tb_stack_sequencer.sv
// ---------------------------------------------------------------------------
// tb_stack_sequencer
//
// Directed bench for stack_sequencer. Each cycle's observation is the tuple
// {ctrl_out, valid_out, stall_fetch, int_ack, int_vec_sel}, compared against
// a hand-computed value just after the rising edge.
// ---------------------------------------------------------------------------
module tb_stack_sequencer;

    logic        clk;
    logic        rst_n;
    logic [33:0] ctrl_in;
    logic        valid_in;
    logic        int_req;
    logic        stall_in;
    logic [33:0] ctrl_out;
    logic        valid_out;
    logic        stall_fetch;
    logic        int_ack;
    logic        int_vec_sel;

    int          n_checks;
    int          n_fail;
    logic [37:0] obs;
    logic [37:0] exp;

    stack_sequencer #(
        .CTRL_W(34),
        .INT_EN(1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ctrl_in    (ctrl_in),
        .valid_in   (valid_in),
        .int_req    (int_req),
        .stall_in   (stall_in),
        .ctrl_out   (ctrl_out),
        .valid_out  (valid_out),
        .stall_fetch(stall_fetch),
        .int_ack    (int_ack),
        .int_vec_sel(int_vec_sel)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        obs = {ctrl_out, valid_out, stall_fetch, int_ack, int_vec_sel};
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ctrl_in = 34'h0; valid_in = 1'b0; int_req = 1'b0; stall_in = 1'b0;
        step();
        step();
        exp = {34'h000000000, 1'b0, 1'b0, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL reset_state: got %h want %h", obs, exp); end
        rst_n = 1'b1;
        step();
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL reset_idle: got %h want %h", obs, exp); end
    endtask

    task automatic test_passthrough();
        ctrl_in = 34'h000200008; valid_in = 1'b1;
        step();
        exp = {34'h000200008, 1'b1, 1'b0, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL pass_add: got %h want %h", obs, exp); end
        ctrl_in = 34'h040000008;
        step();
        exp = {34'h000000008, 1'b1, 1'b0, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL pass_strip: got %h want %h", obs, exp); end
        ctrl_in = 34'h000000040; valid_in = 1'b0;
        step();
        exp = {34'h000000000, 1'b0, 1'b0, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL pass_bubble: got %h want %h", obs, exp); end
    endtask

    task automatic test_call();
        ctrl_in = 34'h000000040; valid_in = 1'b1;
        step();
        exp = {34'h040000002, 1'b1, 1'b1, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL call_w0: got %h want %h", obs, exp); end
        step();
        exp = {34'h000000041, 1'b1, 1'b0, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL call_w1: got %h want %h", obs, exp); end
        valid_in = 1'b0;
        step();
    endtask

    task automatic test_rti_ret();
        ctrl_in = 34'h000000010; valid_in = 1'b1;
        step();
        exp = {34'h200000004, 1'b1, 1'b1, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL rti_w0: got %h want %h", obs, exp); end
        step();
        exp = {34'h100000004, 1'b1, 1'b1, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL rti_w1: got %h want %h", obs, exp); end
        step();
        exp = {34'h000000011, 1'b1, 1'b0, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL rti_w2: got %h want %h", obs, exp); end
        ctrl_in = 34'h000000020;
        step();
        exp = {34'h100000004, 1'b1, 1'b1, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL ret_w0: got %h want %h", obs, exp); end
        step();
        exp = {34'h000000021, 1'b1, 1'b0, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL ret_w1: got %h want %h", obs, exp); end
        valid_in = 1'b0;
        step();
    endtask

    task automatic test_priority();
        // RTI, RET and CALL all set: RTI sequence must win.
        ctrl_in = 34'h000000070; valid_in = 1'b1;
        step();
        exp = {34'h200000004, 1'b1, 1'b1, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL prio_w0: got %h want %h", obs, exp); end
        step();
        step();
        exp = {34'h000000011, 1'b1, 1'b0, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL prio_w2: got %h want %h", obs, exp); end
        valid_in = 1'b0;
        step();
    endtask

    task automatic test_int_during_rti();
        ctrl_in = 34'h000000010; valid_in = 1'b1;
        step();
        // Now in RTI_PC: upstream presents ADD, interrupt pulses one cycle.
        ctrl_in = 34'h000200008; int_req = 1'b1;
        step();
        int_req = 1'b0;
        exp = {34'h100000004, 1'b1, 1'b1, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL irti_w1: got %h want %h", obs, exp); end
        step();
        exp = {34'h000000011, 1'b1, 1'b1, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL irti_w2_pending: got %h want %h", obs, exp); end
        step();
        exp = {34'h040000002, 1'b1, 1'b1, 1'b1, 1'b0};
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL int_push_pc: got %h want %h", obs, exp); end
        step();
        exp = {34'h080000002, 1'b1, 1'b1, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL int_push_flags: got %h want %h", obs, exp); end
        step();
        exp = {34'h000000001, 1'b1, 1'b0, 1'b0, 1'b1};
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL int_branch_vec: got %h want %h", obs, exp); end
        step();
        exp = {34'h000200008, 1'b1, 1'b0, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL int_then_add: got %h want %h", obs, exp); end
        valid_in = 1'b0;
        step();
    endtask

    task automatic test_stall_call();
        ctrl_in = 34'h000000040; valid_in = 1'b1;
        step();
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            // Interrupt arrives during the frozen CALL_FIN; it must still latch.
            int_req = (i == 0) ? 1'b1 : 1'b0;
            step();
            exp = {34'h040000002, 1'b1, 1'b1, 1'b0, 1'b0};
            n_checks++;
            if (obs !== exp) begin n_fail++; $display("FAIL stall_hold_%0d: got %h want %h", i, obs, exp); end
        end
        int_req = 1'b0; stall_in = 1'b0; valid_in = 1'b0;
        step();
        exp = {34'h000000041, 1'b1, 1'b1, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL stall_release: got %h want %h", obs, exp); end
        step();
        exp = {34'h040000002, 1'b1, 1'b1, 1'b1, 1'b0};
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL stall_int_taken: got %h want %h", obs, exp); end
        step();
        step();
        exp = {34'h000000001, 1'b1, 1'b0, 1'b0, 1'b1};
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL stall_int_vec: got %h want %h", obs, exp); end
        step();
        exp = {34'h000000000, 1'b0, 1'b0, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL stall_int_done: got %h want %h", obs, exp); end
    endtask

    task automatic test_reset_mid_int();
        valid_in = 1'b0; int_req = 1'b1;
        step();
        int_req = 1'b0;
        exp = {34'h000000000, 1'b0, 1'b1, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL rst_int_pending: got %h want %h", obs, exp); end
        step();
        exp = {34'h040000002, 1'b1, 1'b1, 1'b1, 1'b0};
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL rst_int_pf: got %h want %h", obs, exp); end
        rst_n = 1'b0;
        step();
        exp = {34'h000000000, 1'b0, 1'b0, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL rst_abort: got %h want %h", obs, exp); end
        rst_n = 1'b1;
        step();
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL rst_no_more_words: got %h want %h", obs, exp); end
    endtask

    // Test sequence.
    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_passthrough();
        test_call();
        test_rti_ret();
        test_priority();
        test_int_during_rti();
        test_stall_call();
        test_reset_mid_int();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stack_sequencer.md
Name: stack_sequencer

Overview:
- Sits between the decode control unit and the ID/EX register, on the consumer side of the 34-bit control word.
- Expands CALL, RET, RTI and external interrupts into multi-cycle stack micro-op words, using PUSH_PC, PUSH_FLAGS, POP_PC and POP_FLAGS (bits 30–33), which the decoder never drives.
- Stalls fetch/decode while a sequence runs. All other instructions pass through with 1-cycle latency.

Parameters:
- CTRL_W, 34, control word width; bit map identical to the decoder's: 0 branch, 1 MemWrite, 2 MemRead, 3 WB, 4 RTI, 5 RET, 6 CALL, 30 PUSH_PC, 31 PUSH_FLAGS, 32 POP_PC, 33 POP_FLAGS.
- INT_EN, 1, 0 = int_req ignored.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- ctrl_in  in  CTRL_W  decoded control word from the control unit.
- valid_in  in  1  ctrl_in holds a real instruction.
- int_req  in  1  external interrupt request, level.
- stall_in  in  1  downstream hazard/memory stall; freezes the block.
- ctrl_out  out  CTRL_W  registered control word to ID/EX.
- valid_out  out  1  ctrl_out is a real slot.
- stall_fetch  out  1  upstream must hold PC, IF/ID and ctrl_in.
- int_ack  out  1  one-cycle pulse when an interrupt is taken.
- int_vec_sel  out  1  PC source = interrupt vector; aligned with the final branch word.

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE, ctrl_out=0, valid_out=0, int_ack=0, int_vec_sel=0, int_pending=0. Reset mid-sequence aborts it, with no further micro-op words.
- int_pending: set at any edge with int_req=1 && INT_EN. Cleared when the interrupt is taken. Sets even during stall_in.
- stall_fetch (combinational) = (state!=IDLE) || int_pending.
- stall_in=1: state, ctrl_out, valid_out, int_vec_sel hold; int_ack forced 0.
- ctrl_in is sampled only in IDLE with stall_in=0 and int_pending=0.
- IDLE edge decisions (stall_in=0):
  - int_pending: emit PUSH_PC|MemWrite, int_ack=1 for the next cycle, clear int_pending, go INT_PF. Interrupt beats ctrl_in; ctrl_in is not consumed.
  - valid_in=0: ctrl_out=0, valid_out=0.
  - RTI (bit 4): emit POP_FLAGS|MemRead, go RTI_PC.
  - RET (bit 5): emit POP_PC|MemRead, go RET_FIN.
  - CALL (bit 6): emit PUSH_PC|MemWrite, go CALL_FIN.
  - Priority when several are set: RTI > RET > CALL.
  - Otherwise: ctrl_out = ctrl_in with bits 30–33 forced to 0, valid_out=1.
- Sequence states; each emits one word and sets valid_out=1:
  - INT_PF: emit PUSH_FLAGS|MemWrite, go INT_FIN.
  - INT_FIN: emit branch only, int_vec_sel=1 for that slot, go IDLE.
  - RTI_PC: emit POP_PC|MemRead, go RTI_FIN.
  - RTI_FIN: emit RTI|branch, go IDLE.
  - RET_FIN: emit RET|branch, go IDLE.
  - CALL_FIN: emit CALL|branch, go IDLE.
- int_vec_sel is 0 in every slot other than the INT_FIN word.
- Output slot counts: CALL/RET 2, RTI 3, interrupt 3. Fetch stall lengths (no stall_in): CALL/RET 1 cycle, RTI 2, interrupt 3 (includes the IDLE cycle with int_pending).
- An interrupt arriving mid-sequence is latched and serviced at the next IDLE; sequences never nest.

Test Plan:
- Passthrough: ctrl_in=34'h000200008 (ADD), valid_in=1 -> next cycle ctrl_out=34'h000200008, valid_out=1, stall_fetch=0. ctrl_in=34'h040000008 -> ctrl_out=34'h000000008 (bit 30 stripped).
- CALL: ctrl_in=34'h000000040 -> ctrl_out 34'h040000002, then 34'h000000041; stall_fetch=1 for exactly 1 cycle.
- RTI: ctrl_in=34'h000000010 -> ctrl_out 34'h200000004, 34'h100000004, 34'h000000011; stall_fetch high 2 cycles. Same for RET: 34'h100000004, then 34'h000000021.
- Interrupt during RTI: int_req pulsed 1 cycle in RTI_PC -> RTI completes, then 34'h040000002 (int_ack=1), 34'h080000002, 34'h000000001 (int_vec_sel=1). ADD held on ctrl_in is emitted only after that.
- stall_in=1 for 3 cycles while in CALL_FIN -> ctrl_out stays 34'h040000002, then 34'h000000041 after release. Separately, rst_n=0 during INT_PF -> next cycle ctrl_out=0, valid_out=0, stall_fetch=0.
